// File: rtl/rk2040_pkg.sv
// -----------------------------------------------------------------------------
// rk2040_pkg
//   Shared definitions for the interrupt controller slice:
//     - default line count and vector width
//     - controller FSM state type
//     - lowest-index-wins priority encoder
//   No ports; imported by the interface, the edge synchronizer and the top.
// -----------------------------------------------------------------------------
package rk2040_pkg;

  localparam int NUM_IRQ_DEFAULT = 24;
  localparam int VEC_W_DEFAULT   = 5;

  // The priority encoder works on a fixed-width vector so one function serves
  // every NUM_IRQ up to IRQ_MAX. Callers zero-extend their request vector.
  localparam int IRQ_MAX = 64;
  localparam int IDX_W   = 6;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVICE
  } ctrlState_e;

  // Returns the index of the lowest set bit (0 when nothing is set; callers
  // qualify the result with a reduction-OR of the same vector). Scanning from
  // the top down lets the lowest set bit make the final assignment.
  function automatic logic [IDX_W-1:0] lowestSetIndex(input logic [IRQ_MAX-1:0] reqVec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = IRQ_MAX - 1; i >= 0; i--) begin
      if (reqVec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// -----------------------------------------------------------------------------
// interrupt_controller_if
//   Bundles the interrupt lines, configuration port and CPU handshake.
//   Signals:
//     inputPort [NUM_IRQ]  asynchronous external interrupt lines
//     cfgWe                configuration write strobe
//     cfgSel               0 = mask register, 1 = polarity register
//     cfgData   [NUM_IRQ]  configuration write data
//     irqAck               CPU accepts the presented vector
//     irqDone              CPU return-from-interrupt pulse
//     irqReq               interrupt request to the CPU
//     irqVector [VEC_W]    index of the requested line
//     pending   [NUM_IRQ]  latched pending bits
//     inService            high while a handler runs
//   Modports: master = CPU/system side, slave = controller side.
// -----------------------------------------------------------------------------
interface interrupt_controller_if
  import rk2040_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
  parameter int VEC_W   = VEC_W_DEFAULT
) ();

  logic [NUM_IRQ-1:0] inputPort;
  logic               cfgWe;
  logic               cfgSel;
  logic [NUM_IRQ-1:0] cfgData;
  logic               irqAck;
  logic               irqDone;
  logic               irqReq;
  logic [VEC_W-1:0]   irqVector;
  logic [NUM_IRQ-1:0] pending;
  logic               inService;

  modport master (
    output inputPort, cfgWe, cfgSel, cfgData, irqAck, irqDone,
    input  irqReq, irqVector, pending, inService
  );

  modport slave (
    input  inputPort, cfgWe, cfgSel, cfgData, irqAck, irqDone,
    output irqReq, irqVector, pending, inService
  );

endinterface

// File: rtl/irq_edge_sync.sv
// -----------------------------------------------------------------------------
// irq_edge_sync
//   Per-line 2-flop synchronizer followed by a polarity-selectable edge
//   detector. A one-cycle pulse appears on edgePulse[i] while sync2 and prev
//   differ in the direction chosen by polarity[i].
//   Ports:
//     clk                  system clock
//     rst                  synchronous active-high reset
//     asyncIn   [NUM_IRQ]  raw asynchronous lines
//     polarity  [NUM_IRQ]  0 = falling edge, 1 = rising edge
//     edgePulse [NUM_IRQ]  detected edge, valid for one cycle
// -----------------------------------------------------------------------------
module irq_edge_sync
  import rk2040_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] asyncIn,
  input  logic [NUM_IRQ-1:0] polarity,
  output logic [NUM_IRQ-1:0] edgePulse
);

  logic [NUM_IRQ-1:0] sync1;
  logic [NUM_IRQ-1:0] sync2;
  logic [NUM_IRQ-1:0] prev;

  // Clearing the whole pipeline on reset means any line activity sampled
  // while rst is high is dropped, and the first edges after reset are judged
  // against an all-zero history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage capture the previous
      // stage's old value; blocking ones would collapse the chain to one flop.
      sync1 <= asyncIn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edgePulse = ( polarity &  sync2 & ~prev)
                   | (~polarity & ~sync2 &  prev);

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//   Edge-triggered, single-level interrupt controller. Lines are synchronized
//   and edge-detected, latched into one-deep pending bits, masked, and the
//   lowest pending unmasked index is presented to the CPU. A three-state FSM
//   (IDLE -> REQUEST -> SERVICE -> IDLE) runs the handshake; no nesting.
//   Ports:
//     clk   system clock, all state changes on the rising edge
//     rst   synchronous active-high reset
//     bus   interrupt_controller_if.slave (lines, config, CPU handshake)
//   Register state: mask (reset all-ones), polarity (reset 0), pending,
//   FSM state, latched vector, registered irqReq / inService.
// -----------------------------------------------------------------------------
module interrupt_controller
  import rk2040_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
  parameter int VEC_W   = VEC_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_controller_if.slave bus
);

  logic [NUM_IRQ-1:0] maskReg;
  logic [NUM_IRQ-1:0] polarityReg;
  logic [NUM_IRQ-1:0] pendingReg;
  logic [NUM_IRQ-1:0] edgePulse;
  logic [NUM_IRQ-1:0] ackClear;
  logic [IRQ_MAX-1:0] candidates;
  logic [VEC_W-1:0]   nextVector;
  logic               ackFire;

  ctrlState_e         state;
  logic               irqReqReg;
  logic               inServiceReg;
  logic [VEC_W-1:0]   vectorReg;

  // ---------------------------------------------------------------------------
  // Line synchronization and edge detection
  // ---------------------------------------------------------------------------
  irq_edge_sync #(
    .NUM_IRQ (NUM_IRQ)
  ) edgeSyncInst (
    .clk       (clk),
    .rst       (rst),
    .asyncIn   (bus.inputPort),
    .polarity  (polarityReg),
    .edgePulse (edgePulse)
  );

  // ---------------------------------------------------------------------------
  // Configuration registers: a write lands on the same edge as cfgWe, so the
  // FSM and edge detector see the new value from the following cycle on.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      maskReg     <= '1;
      polarityReg <= '0;
    end else if (bus.cfgWe) begin
      if (bus.cfgSel) polarityReg <= bus.cfgData;
      else            maskReg     <= bus.cfgData;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration and acknowledge decode
  // ---------------------------------------------------------------------------
  assign ackFire = (state == REQUEST) && bus.irqAck;

  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // that no path leaves it unassigned and no latch is inferred.
    candidates                = '0;
    candidates[NUM_IRQ-1:0]   = pendingReg & maskReg;
    nextVector                = VEC_W'(lowestSetIndex(candidates));
    ackClear                  = '0;
    if (ackFire) ackClear[vectorReg] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Pending bits: one deep per line. A fresh edge is OR-ed in after the ack
  // clear, so an edge landing in the ack cycle re-pends the line rather than
  // being lost; repeated edges on an already pending line simply merge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) pendingReg <= '0;
    else     pendingReg <= (pendingReg & ~ackClear) | edgePulse;
  end

  // ---------------------------------------------------------------------------
  // Controller FSM with registered outputs. IDLE always lasts at least one
  // cycle, which gives the CPU a gap between back-to-back requests. Mask
  // clears are seen through the registered mask, and an ack in the same
  // cycle takes precedence over withdrawing the request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      irqReqReg    <= 1'b0;
      inServiceReg <= 1'b0;
      vectorReg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|candidates) begin
            vectorReg <= nextVector;
            irqReqReg <= 1'b1;
            state     <= REQUEST;
          end
        end
        REQUEST: begin
          if (bus.irqAck) begin
            irqReqReg    <= 1'b0;
            inServiceReg <= 1'b1;
            state        <= SERVICE;
          end else if (!maskReg[vectorReg]) begin
            // Request withdrawn; the pending bit stays for later service.
            irqReqReg <= 1'b0;
            state     <= IDLE;
          end
        end
        SERVICE: begin
          if (bus.irqDone) begin
            inServiceReg <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          irqReqReg    <= 1'b0;
          inServiceReg <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.irqReq    = irqReqReg;
  assign bus.irqVector = vectorReg;
  assign bus.pending   = pendingReg;
  assign bus.inService = inServiceReg;

endmodule
